// File: rtl/pwm_sched_ctrl.sv
// PWM sequencing controller: free-running period timer, registered PWM output, and a
// shadowed period/duty update path that only commits on a period boundary.
module pwm_sched_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_DUTY   = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_err,
  output logic             out,
  output logic [WIDTH-1:0] timer,
  output logic             period_end,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEF_DUTY);

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] timer_q, timer_nx;
  logic [WIDTH-1:0] act_period_q, act_period_nx;
  logic [WIDTH-1:0] act_duty_q, act_duty_nx;
  logic [WIDTH-1:0] shd_period_q, shd_period_nx;
  logic [WIDTH-1:0] shd_duty_q, shd_duty_nx;
  logic             out_q, out_nx;
  logic             cfg_err_q, cfg_err_nx;
  logic             accept, cfg_ok, boundary;

  assign cfg_ready  = (state_q != PEND);
  assign running    = (state_q != IDLE);
  assign accept     = cfg_valid && cfg_ready;
  assign cfg_ok     = accept && (cfg_period != '0);
  assign boundary   = (state_q != IDLE) && (timer_q == act_period_q - ONE);
  assign period_end = boundary;
  assign timer      = timer_q;
  assign out        = out_q;
  assign cfg_err    = cfg_err_q;

  always_comb begin
    state_nx      = state_q;
    timer_nx      = timer_q;
    act_period_nx = act_period_q;
    act_duty_nx   = act_duty_q;
    shd_period_nx = shd_period_q;
    shd_duty_nx   = shd_duty_q;
    cfg_err_nx    = accept && (cfg_period == '0);
    case (state_q)
      IDLE: begin
        timer_nx = '0;
        if (cfg_ok) begin
          act_period_nx = cfg_period;
          act_duty_nx   = cfg_duty;
        end
        if (en) state_nx = RUN;
      end
      RUN: begin
        if (boundary) begin
          timer_nx = '0;
          if (!en) begin
            state_nx = IDLE;
            // Stopping: no later boundary exists, so a same-edge config lands directly.
            if (cfg_ok) begin
              act_period_nx = cfg_period;
              act_duty_nx   = cfg_duty;
            end
          end else if (cfg_ok) begin
            shd_period_nx = cfg_period;
            shd_duty_nx   = cfg_duty;
            state_nx      = PEND;
          end
        end else begin
          timer_nx = timer_q + ONE;
          if (cfg_ok) begin
            shd_period_nx = cfg_period;
            shd_duty_nx   = cfg_duty;
            state_nx      = PEND;
          end
        end
      end
      PEND: begin
        if (boundary) begin
          timer_nx      = '0;
          act_period_nx = shd_period_q;
          act_duty_nx   = shd_duty_q;
          shd_period_nx = '0;
          shd_duty_nx   = '0;
          state_nx      = en ? RUN : IDLE;
        end else begin
          timer_nx = timer_q + ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
    // Output uses next-cycle timer and settings so a new period starts with its own duty.
    out_nx = (state_nx != IDLE) && (timer_nx < act_duty_nx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      out_q        <= 1'b0;
      cfg_err_q    <= 1'b0;
      act_period_q <= DEF_P;
      act_duty_q   <= DEF_D;
      shd_period_q <= '0;
      shd_duty_q   <= '0;
    end else begin
      state_q      <= state_nx;
      timer_q      <= timer_nx;
      out_q        <= out_nx;
      cfg_err_q    <= cfg_err_nx;
      act_period_q <= act_period_nx;
      act_duty_q   <= act_duty_nx;
      shd_period_q <= shd_period_nx;
      shd_duty_q   <= shd_duty_nx;
    end
  end

endmodule

// File: tb/tb_pwm_sched_ctrl.sv
// Bench for pwm_sched_ctrl: directed scenarios plus random traffic, checked every cycle
// against a period/duty reference model built from modular timer arithmetic.
module tb_pwm_sched_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty = '0;
  logic         cfg_err;
  logic         out;
  logic [W-1:0] timer;
  logic         period_end;
  logic         running;

  pwm_sched_ctrl #(.WIDTH(W), .DEF_PERIOD(100), .DEF_DUTY(50)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_err(cfg_err),
    .out(out), .timer(timer), .period_end(period_end), .running(running)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "on" flag, position inside the period, active and pending settings.
  bit          m_on, m_has_pending, m_err;
  int unsigned m_pos, m_per, m_duty, m_pend_per, m_pend_duty;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_has_pending = 0; m_err = 0;
    m_pos = 0; m_per = 100; m_duty = 50; m_pend_per = 0; m_pend_duty = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int unsigned p, input int unsigned d);
    bit acc, good, last;
    acc  = v && !m_has_pending;
    good = acc && (p != 0);
    m_err = acc && (p == 0);
    if (!m_on) begin
      if (good) begin m_per = p; m_duty = d; end
      m_pos = 0;
      m_on  = e;
    end else begin
      last  = ((m_pos + 1) % m_per) == 0;
      m_pos = (m_pos + 1) % m_per;
      if (last) begin
        if (m_has_pending) begin
          m_per = m_pend_per; m_duty = m_pend_duty; m_has_pending = 0;
        end else if (good && e) begin
          m_pend_per = p; m_pend_duty = d; m_has_pending = 1;
        end else if (good) begin
          m_per = p; m_duty = d;
        end
        if (!e) m_on = 0;
      end else if (good) begin
        m_pend_per = p; m_pend_duty = d; m_has_pending = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("timer", timer, m_on ? m_pos : 0);
    check("out", W'(out), W'(m_on && (m_pos < m_duty)));
    check("running", W'(running), W'(m_on));
    check("cfg_ready", W'(cfg_ready), W'(!m_has_pending));
    check("period_end", W'(period_end), W'(m_on && (m_pos == m_per - 1)));
    check("cfg_err", W'(cfg_err), W'(m_err));
  endtask

  task automatic tick();
    bit          e, v;
    int unsigned p, d;
    bit          r;
    e = en; v = cfg_valid; p = cfg_period; d = cfg_duty; r = rst;
    @(posedge clk);
    if (r) model_reset();
    else model_step(e, v, p, d);
    #1;
    compare_all();
  endtask

  task automatic wait_pos(input int unsigned target);
    int n;
    n = 0;
    while (!(m_on && m_pos == target) && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      n_cmp++; n_bad++;
      $error("FAIL wait_pos: observed timeout expected timer %0d", target);
    end
  endtask

  task automatic send_cfg(input int unsigned p, input int unsigned d);
    cfg_valid = 1'b1; cfg_period = W'(p); cfg_duty = W'(d);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cnt += int'(out);
      tick();
    end
  endtask

  initial begin
    int cnt, n;
    model_reset();
    #1;
    check("rst_timer", timer, 0);
    check("rst_out", W'(out), 0);
    check("rst_ready", W'(cfg_ready), 1);
    check("rst_running", W'(running), 0);
    tick();
    rst = 1'b0;
    tick();

    // Defaults: 100-cycle period, 50 high
    en = 1'b1;
    tick();
    count_high(100, cnt);
    check("s1_high", W'(cnt), 50);
    count_high(100, cnt);
    check("s1_high2", W'(cnt), 50);

    // Stop, then configure while idle
    en = 1'b0;
    n = 0;
    while (running && n < 300) begin tick(); n++; end
    send_cfg(10, 3);
    en = 1'b1;
    tick();
    count_high(10, cnt);
    check("s2_high", W'(cnt), 3);

    // Mid-period update holds until the wrap
    wait_pos(4);
    send_cfg(20, 15);
    check("s3_ready_low", W'(cfg_ready), 0);
    wait_pos(0);
    count_high(20, cnt);
    check("s3_high", W'(cnt), 15);

    // Back to 10/3, then update on the boundary edge
    send_cfg(10, 3);
    wait_pos(0);
    wait_pos(9);
    send_cfg(6, 2);
    count_high(10, cnt);
    check("s4_old_period", W'(cnt), 3);
    count_high(6, cnt);
    check("s4_new_period", W'(cnt), 2);

    // Rejected config and duty extremes
    send_cfg(0, 7);
    check("s5_err_pulse", W'(cfg_err), 1);
    tick();
    check("s5_err_clear", W'(cfg_err), 0);
    send_cfg(5, 0);
    wait_pos(0);
    count_high(5, cnt);
    check("s5_duty0", W'(cnt), 0);
    send_cfg(5, 7);
    wait_pos(0);
    count_high(5, cnt);
    check("s5_duty_full", W'(cnt), 5);
    send_cfg(1, 1);
    wait_pos(0);
    tick(); tick(); tick();

    // Stop mid-period runs to the boundary
    send_cfg(10, 3);
    wait_pos(0);
    wait_pos(2);
    en = 1'b0;
    n = 0;
    while (running && n < 50) begin tick(); n++; end
    check("s6_stop_cycles", W'(n), 8);
    check("s6_idle_out", W'(out), 0);

    // Asynchronous reset mid-period
    en = 1'b1;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("s6_arst_timer", timer, 0);
    check("s6_arst_out", W'(out), 0);
    check("s6_arst_running", W'(running), 0);
    tick();
    rst = 1'b0;
    tick();
    count_high(100, cnt);
    check("s6_defaults", W'(cnt), 50);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en         = ($urandom_range(0, 15) != 0);
      cfg_valid  = ($urandom_range(0, 4) == 0);
      cfg_period = W'($urandom_range(0, 12));
      cfg_duty   = W'($urandom_range(0, 14));
      tick();
    end
    cfg_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
